// File: rtl/ysyx_24100012_csr_trap_unit.sv
// ysyx_24100012_csr_trap_unit: machine-mode CSR file with trap sequencing
// (interrupt, ecall/ebreak, mret) for the NPC core.
// Optional feature macro: YSYX_CSR_COUNTERS_EN. When defined, the 64-bit
// mcycle/minstret counters are implemented. When undefined, their indices
// read as zero, are legal, and ignore writes.
module ysyx_24100012_csr_trap_unit #(
  parameter int              XLEN      = 32,
  parameter int              CNT_W     = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [1:0]      sys_op,
  input  logic [XLEN-1:0] pc,
  input  logic            irq_timer,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect,
  output logic [XLEN-1:0] trap_pc
);

  localparam logic [11:0] IDX_MSTATUS   = 12'h300;
  localparam logic [11:0] IDX_MIE       = 12'h304;
  localparam logic [11:0] IDX_MTVEC     = 12'h305;
  localparam logic [11:0] IDX_MSCRATCH  = 12'h340;
  localparam logic [11:0] IDX_MEPC      = 12'h341;
  localparam logic [11:0] IDX_MCAUSE    = 12'h342;
  localparam logic [11:0] IDX_MIP       = 12'h344;
  localparam logic [11:0] IDX_MCYCLE    = 12'hB00;
  localparam logic [11:0] IDX_MINSTRET  = 12'hB02;
  localparam logic [11:0] IDX_MCYCLEH   = 12'hB80;
  localparam logic [11:0] IDX_MINSTRETH = 12'hB82;
  localparam logic [11:0] IDX_MVENDOR   = 12'hF11;
  localparam logic [11:0] IDX_MARCH     = 12'hF12;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, {(XLEN-4){1'b0}}, 3'b111};
  localparam logic [XLEN-1:0] ECALL_CAUSE  = XLEN'(11);
  localparam logic [XLEN-1:0] EBREAK_CAUSE = XLEN'(3);
  localparam logic [XLEN-1:0] VENDOR_ID  = XLEN'(32'h7973_7978);
  localparam logic [XLEN-1:0] ARCH_ID    = XLEN'(32'd24100012);

  // mstatus keeps only MIE/MPIE as state; MPP reads back as 2'b11
  logic            mst_mie, mst_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;

  logic [2*XLEN-1:0] cyc_ext, ins_ext;
  logic [XLEN-1:0]   csr_old, csr_nv;
  logic              idx_known, idx_ro, wr_effect;
  logic              irq_take, exc_take, mret_take, csr_we;

  // Read mux: old value of the addressed CSR plus index classification
  always_comb begin
    csr_old   = '0;
    idx_known = 1'b1;
    idx_ro    = 1'b0;
    case (csr_idx)
      IDX_MSTATUS: begin
        csr_old[12:11] = 2'b11;
        csr_old[7]     = mst_mpie;
        csr_old[3]     = mst_mie;
      end
      IDX_MIE:       csr_old = mie_q;
      IDX_MTVEC:     csr_old = mtvec_q;
      IDX_MSCRATCH:  csr_old = mscratch_q;
      IDX_MEPC:      csr_old = mepc_q;
      IDX_MCAUSE:    csr_old = mcause_q;
      IDX_MIP: begin
        csr_old[7] = irq_timer;
        idx_ro     = 1'b1;
      end
      IDX_MCYCLE:    csr_old = cyc_ext[XLEN-1:0];
      IDX_MCYCLEH:   csr_old = cyc_ext[2*XLEN-1:XLEN];
      IDX_MINSTRET:  csr_old = ins_ext[XLEN-1:0];
      IDX_MINSTRETH: csr_old = ins_ext[2*XLEN-1:XLEN];
      IDX_MVENDOR: begin
        csr_old = VENDOR_ID;
        idx_ro  = 1'b1;
      end
      IDX_MARCH: begin
        csr_old = ARCH_ID;
        idx_ro  = 1'b1;
      end
      default:       idx_known = 1'b0;
    endcase
  end

  // New CSR value and trap/write qualification; set/clear with zero mask is a pure read
  always_comb begin
    case (csr_op)
      2'b01:   csr_nv = csr_wdata;
      2'b10:   csr_nv = csr_old | csr_wdata;
      2'b11:   csr_nv = csr_old & ~csr_wdata;
      default: csr_nv = csr_old;
    endcase
    wr_effect   = (csr_op == 2'b01) || (csr_op[1] && (|csr_wdata));
    csr_illegal = instr_valid && (csr_op != 2'b00) && (!idx_known || (idx_ro && wr_effect));
    irq_take    = instr_valid && irq_timer && mst_mie && mie_q[7];
    exc_take    = instr_valid && !irq_take && (sys_op == 2'b01 || sys_op == 2'b10);
    mret_take   = instr_valid && !irq_take && !exc_take && (sys_op == 2'b11);
    csr_we      = instr_valid && !irq_take && !exc_take && !mret_take && wr_effect && !csr_illegal;
    redirect    = irq_take || exc_take || mret_take;
    if (irq_take || exc_take) trap_pc = mtvec_q;
    else if (mret_take)       trap_pc = mepc_q;
    else                      trap_pc = '0;
  end

  assign csr_rdata = csr_old;

  // Architectural CSR state: traps outrank mret, which outranks the CSR write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (irq_take) begin
      mepc_q   <= (pc + XLEN'(4)) & ALIGN_MASK;
      mcause_q <= IRQ_CAUSE;
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (exc_take) begin
      mepc_q   <= pc & ALIGN_MASK;
      mcause_q <= (sys_op == 2'b10) ? EBREAK_CAUSE : ECALL_CAUSE;
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (mret_take) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr_idx)
        IDX_MSTATUS: begin
          mst_mie  <= csr_nv[3];
          mst_mpie <= csr_nv[7];
        end
        IDX_MIE:      mie_q      <= csr_nv;
        IDX_MTVEC:    mtvec_q    <= csr_nv & ALIGN_MASK;
        IDX_MSCRATCH: mscratch_q <= csr_nv;
        IDX_MEPC:     mepc_q     <= csr_nv & ALIGN_MASK;
        IDX_MCAUSE:   mcause_q   <= csr_nv;
        default: ;
      endcase
    end
  end

`ifdef YSYX_CSR_COUNTERS_EN
  logic [CNT_W-1:0] mcycle_q, minstret_q;
  logic             cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  assign cyc_ext   = (2*XLEN)'(mcycle_q);
  assign ins_ext   = (2*XLEN)'(minstret_q);
  assign cyc_wr_lo = csr_we && (csr_idx == IDX_MCYCLE);
  assign cyc_wr_hi = csr_we && (csr_idx == IDX_MCYCLEH);
  assign ins_wr_lo = csr_we && (csr_idx == IDX_MINSTRET);
  assign ins_wr_hi = csr_we && (csr_idx == IDX_MINSTRETH);

  // Counters: a write to either half replaces the whole counter's increment that cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (cyc_wr_lo)      mcycle_q <= CNT_W'({cyc_ext[2*XLEN-1:XLEN], csr_nv});
      else if (cyc_wr_hi) mcycle_q <= CNT_W'({csr_nv, cyc_ext[XLEN-1:0]});
      else                mcycle_q <= mcycle_q + CNT_W'(1);
      if (ins_wr_lo)        minstret_q <= CNT_W'({ins_ext[2*XLEN-1:XLEN], csr_nv});
      else if (ins_wr_hi)   minstret_q <= CNT_W'({csr_nv, ins_ext[XLEN-1:0]});
      else if (instr_valid) minstret_q <= minstret_q + CNT_W'(1);
    end
  end
`else
  assign cyc_ext = '0;
  assign ins_ext = '0;
`endif

endmodule

// File: doc/ysyx_24100012_csr_trap_unit.md
# ysyx_24100012_csr_trap_unit

Machine-mode CSR file with trap sequencing, replacing the fixed five-register CSR block in the NPC core. Parametrised in data width and counter width. Adds csrrs/csrrc semantics, mstatus MIE/MPIE stacking, ebreak, a level-sensitive machine timer interrupt, mscratch/mie/mip, and 64-bit cycle/instret counters. Sits beside the register file. IDU/EXU drive op and index; the PC mux takes `trap_pc` when `redirect` is high.

## Interface
- `XLEN`, 32, data/address width
- `CNT_W`, 64, mcycle/minstret width (≤ 2·XLEN)
- `MTVEC_RST`, 0, mtvec reset value
- `clk  in  1  clock, rising edge`
- `rst  in  1  asynchronous, active-low reset`
- `instr_valid  in  1  one instruction retires this cycle (qualifies every input below)`
- `csr_op  in  2  00 none, 01 csrrw, 10 csrrs, 11 csrrc`
- `csr_idx  in  12  CSR address`
- `csr_wdata  in  XLEN  rs1 value or zero-extended uimm`
- `sys_op  in  2  00 none, 01 ecall, 10 ebreak, 11 mret`
- `pc  in  XLEN  PC of retiring instruction`
- `irq_timer  in  1  machine timer interrupt, level`
- `csr_rdata  out  XLEN  old CSR value, combinational`
- `csr_illegal  out  1  csr_op≠0 with unknown index, or write to read-only CSR`
- `redirect  out  1  take `trap_pc` this cycle`
- `trap_pc  out  XLEN  target PC when `redirect`=1, else 0`

## Operation
- CSRs (index → reset): mstatus 0x300 → 0x1800, mie 0x304 → 0, mtvec 0x305 → MTVEC_RST, mscratch 0x340 → 0, mepc 0x341 → 0, mcause 0x342 → 0, mip 0x344 (read-only, bit7 = irq_timer), mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82 → 0, mvendorid 0xF11 / marchid 0xF12 (read-only, 0x79737978 / 24100012).
- mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] is hard-wired to 2'b11.
- mtvec[1:0] is forced to 00 (direct mode only). mepc[1:0] is forced to 00.
- New value: rw → wdata, rs → old|wdata, rc → old&~wdata. For rs/rc with wdata=0, no write side effect, and read-only CSRs are not illegal in that case.
- An illegal access suppresses the write. No trap is raised; csr_illegal is reported only.
- Priority per retiring instruction (instr_valid=1):
  - 1 interrupt: irq_timer & mstatus.MIE & mie[7]
  - 2 ecall/ebreak
  - 3 mret
  - 4 CSR write
- Interrupt: mepc←pc+4, mcause←{1,…,7}, MPIE←MIE, MIE←0, trap_pc=mtvec. The instruction's CSR write and sys_op are discarded.
- ecall: mcause←11. ebreak: mcause←3. Both: mepc←pc, MPIE←MIE, MIE←0, trap_pc=mtvec.
- mret: MIE←MPIE, MPIE←1, trap_pc=mepc.
- mcycle increments every cycle out of reset. minstret increments on instr_valid, including trapping instructions.
- A CSR write to a counter half has priority over that counter's increment in the same cycle.
- mcycleh/minstreth map CNT_W-1:XLEN. Bits above CNT_W read 0.

## Timing
- csr_rdata, csr_illegal, redirect and trap_pc are combinational from the current inputs and state. No latency.
- All state updates occur at the rising clk edge of the retiring cycle and are visible the next cycle.
- When instr_valid=0: no state change except mcycle; redirect=0.
- rst low forces all CSRs to their reset values immediately. Release is synchronous to clk. Counters start at 0 on the first edge after release.
- mcycle wraps from 2^CNT_W−1 to 0 with no flag.

## Configuration
- `YSYX_CSR_COUNTERS_EN` defined: mcycle/minstret (and high halves) are implemented as above.
- Undefined: the counter registers are absent. Reads of 0xB00/0xB02/0xB80/0xB82 return 0 and are legal. Writes are ignored.

## Test plan
- Reset: rst low mid-run → mstatus=0x1800, mtvec=MTVEC_RST, mepc=0, mcycle=0 with no clock edge needed.
- csrrs mtvec, wdata=0x8000_0003 after csrrw 0x8000_0000 → readback 0x8000_0000. Then csrrc 0x8000_0000 → 0.
- ecall at pc=0x8000_0100 with mtvec=0x8000_0200, MIE=1 → redirect, trap_pc=0x8000_0200; next cycle mepc=0x8000_0100, mcause=11, MIE=0, MPIE=1. Then mret → trap_pc=0x8000_0100, MIE=1.
- irq_timer=1, mie=0x80, MIE=1, concurrent csrrw mscratch at pc=0x8000_0010 → mcause=0x8000_0007, mepc=0x8000_0014, mscratch unchanged. Repeat with MIE=0 → no redirect.
- csrrw mcycle=0xFFFF_FFFF, mcycleh=0 → next cycle mcycleh=1, mcycle=0. csrrw 0xF11 → csr_illegal=1, value unchanged.
- Build without YSYX_CSR_COUNTERS_EN: read 0xB00 after 100 cycles → 0, csr_illegal=0.
